// File: rtl/led_pattern_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : led_pattern_ctrl_pkg                                         |
// | Desc   : Shared mode encoding, colour reset value, direction codes    |
// |          and small helpers for the LED pattern engine.               |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package led_pattern_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'd0,
    MODE_FLASH  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  localparam logic [2:0] COLOR_RST = 3'b001;
  localparam logic       DIR_LEFT  = 1'b0;
  localparam logic       DIR_RIGHT = 1'b1;

  // SHIFT and BOUNCE start from a single lit LED, FLASH and FILL from dark.
  function automatic logic init_is_one(input mode_e m);
    return (m == MODE_SHIFT) || (m == MODE_BOUNCE);
  endfunction

  // Mode advance wraps FILL back to SHIFT.
  function automatic mode_e next_mode(input mode_e m);
    logic [1:0] v;
    v = m + 2'd1;
    return mode_e'(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : led_pattern_ctrl_if                                          |
// | Desc   : Control/button inputs and LED outputs of the pattern engine. |
// |          master = board side, slave = pattern engine.                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface led_pattern_ctrl_if #(
  parameter int N_LEDS = 4
) ();

  logic              i_enable;
  logic [1:0]        i_period_sel;
  logic              i_dir;
  logic              i_btn_mode;
  logic [2:0]        i_btn_color;
  logic [N_LEDS-1:0] o_led_r;
  logic [N_LEDS-1:0] o_led_g;
  logic [N_LEDS-1:0] o_led_b;
  logic [1:0]        o_mode;
  logic              o_tick;

  modport master (
    output i_enable, i_period_sel, i_dir, i_btn_mode, i_btn_color,
    input  o_led_r, o_led_g, o_led_b, o_mode, o_tick
  );

  modport slave (
    input  i_enable, i_period_sel, i_dir, i_btn_mode, i_btn_color,
    output o_led_r, o_led_g, o_led_b, o_mode, o_tick
  );

endinterface
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : led_tick_gen                                                 |
// | Desc   : Programmable tick generator. Emits a registered one-cycle    |
// |          pulse every PERIODsel clocks while enabled.                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module led_tick_gen #(
  parameter int          N_COUNT = 32,
  parameter int unsigned PERIOD0 = 10_000_000,
  parameter int unsigned PERIOD1 = 25_000_000,
  parameter int unsigned PERIOD2 = 50_000_000,
  parameter int unsigned PERIOD3 = 100_000_000
) (
  input  wire logic       i_clk,
  input  wire logic       i_reset,
  input  wire logic       i_enable,
  input  wire logic [1:0] i_period_sel,
  input  wire logic       i_clear,
  output logic            o_tick
);

  localparam logic [N_COUNT-1:0] LIMIT0 = N_COUNT'(PERIOD0 - 1);
  localparam logic [N_COUNT-1:0] LIMIT1 = N_COUNT'(PERIOD1 - 1);
  localparam logic [N_COUNT-1:0] LIMIT2 = N_COUNT'(PERIOD2 - 1);
  localparam logic [N_COUNT-1:0] LIMIT3 = N_COUNT'(PERIOD3 - 1);

  logic [N_COUNT-1:0] cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [N_COUNT-1:0] limit;

  // Terminal count for the selected period.
  always_comb begin
    limit = LIMIT0;
    case (i_period_sel)
      2'd0:    limit = LIMIT0;
      2'd1:    limit = LIMIT1;
      2'd2:    limit = LIMIT2;
      default: limit = LIMIT3;
    endcase
  end

  // Count up; >= lets an over-limit count wrap at once after a period change.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!i_enable || i_clear) begin
      cnt_d = '0;
    end else if (cnt_q >= limit) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : led_pattern_ctrl                                             |
// | Desc   : RGB LED pattern engine: SHIFT/FLASH/BOUNCE/FILL patterns     |
// |          advanced by an internal tick, button-driven mode and colour. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module led_pattern_ctrl
  import led_pattern_ctrl_pkg::*;
#(
  parameter int          N_LEDS  = 4,
  parameter int          N_COUNT = 32,
  parameter int unsigned PERIOD0 = 10_000_000,
  parameter int unsigned PERIOD1 = 25_000_000,
  parameter int unsigned PERIOD2 = 50_000_000,
  parameter int unsigned PERIOD3 = 100_000_000
) (
  input  wire logic         i_clk,
  input  wire logic         i_reset,
  led_pattern_ctrl_if.slave bus
);

  localparam logic [N_LEDS-1:0] PAT_ONE = N_LEDS'(1);

  mode_e             mode_q, mode_d;
  logic [N_LEDS-1:0] pat_q, pat_d;
  logic [2:0]        color_q, color_d;
  logic              heading_q, heading_d;
  logic              btn_mode_prev_q, btn_mode_prev_d;
  logic [2:0]        btn_color_prev_q, btn_color_prev_d;

  logic              tick;
  logic              mode_edge;
  logic [2:0]        color_edge;
  mode_e             mode_nx;

  assign mode_edge  = bus.i_btn_mode & ~btn_mode_prev_q;
  assign color_edge = bus.i_btn_color & ~btn_color_prev_q;
  assign mode_nx    = next_mode(mode_q);

  // A mode change restarts the tick period so the new pattern gets a full first step.
  led_tick_gen #(
    .N_COUNT (N_COUNT),
    .PERIOD0 (PERIOD0),
    .PERIOD1 (PERIOD1),
    .PERIOD2 (PERIOD2),
    .PERIOD3 (PERIOD3)
  ) u_tick_gen (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_enable     (bus.i_enable),
    .i_period_sel (bus.i_period_sel),
    .i_clear      (mode_edge),
    .o_tick       (tick)
  );

  // Next-state: button edges, colour latch, and pattern step (mode edge beats tick).
  always_comb begin
    mode_d           = mode_q;
    pat_d            = pat_q;
    color_d          = color_q;
    heading_d        = heading_q;
    btn_mode_prev_d  = bus.i_btn_mode;
    btn_color_prev_d = bus.i_btn_color;

    if (color_edge != 3'b000) begin
      color_d = bus.i_btn_color;
    end

    if (mode_edge) begin
      mode_d    = mode_nx;
      pat_d     = init_is_one(mode_nx) ? PAT_ONE : '0;
      heading_d = DIR_LEFT;
    end else if (tick) begin
      case (mode_q)
        MODE_SHIFT: begin
          if (bus.i_dir == DIR_RIGHT) pat_d = {pat_q[0], pat_q[N_LEDS-1:1]};
          else                        pat_d = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
        end
        MODE_FLASH: begin
          pat_d = ~pat_q;
        end
        MODE_BOUNCE: begin
          // Reverse when the lit LED is already at the end it is heading for.
          if (heading_q == DIR_LEFT) begin
            if (pat_q[N_LEDS-1]) begin
              pat_d     = pat_q >> 1;
              heading_d = DIR_RIGHT;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q[0]) begin
              pat_d     = pat_q << 1;
              heading_d = DIR_LEFT;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
        end
        MODE_FILL: begin
          if (&pat_q)                      pat_d = '0;
          else if (bus.i_dir == DIR_RIGHT) pat_d = {1'b1, pat_q[N_LEDS-1:1]};
          else                             pat_d = {pat_q[N_LEDS-2:0], 1'b1};
        end
        default: pat_d = pat_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      mode_q           <= MODE_SHIFT;
      pat_q            <= PAT_ONE;
      color_q          <= COLOR_RST;
      heading_q        <= DIR_LEFT;
      btn_mode_prev_q  <= 1'b0;
      btn_color_prev_q <= 3'b000;
    end else begin
      mode_q           <= mode_d;
      pat_q            <= pat_d;
      color_q          <= color_d;
      heading_q        <= heading_d;
      btn_mode_prev_q  <= btn_mode_prev_d;
      btn_color_prev_q <= btn_color_prev_d;
    end
  end

  assign bus.o_led_r = color_q[0] ? pat_q : '0;
  assign bus.o_led_g = color_q[1] ? pat_q : '0;
  assign bus.o_led_b = color_q[2] ? pat_q : '0;
  assign bus.o_mode  = mode_q;
  assign bus.o_tick  = tick;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_led_pattern_ctrl                                          |
// | Desc   : Scoreboard bench for led_pattern_ctrl with a reference model.|
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_led_pattern_ctrl;

  localparam int N    = 4;
  localparam int MASK = (1 << N) - 1;

  typedef struct packed {
    logic [N-1:0] r;
    logic [N-1:0] g;
    logic [N-1:0] b;
    logic [1:0]   mode;
    logic         tick;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_pattern_ctrl_if #(.N_LEDS(N)) bus ();

  led_pattern_ctrl #(
    .N_LEDS  (N),
    .N_COUNT (32),
    .PERIOD0 (4),
    .PERIOD1 (8),
    .PERIOD2 (2),
    .PERIOD3 (16)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state: pattern as an integer, bounce as a position + heading.
  int m_cnt, m_tick, m_mode, m_col, m_pat, m_pos, m_left, m_pbm, m_pbc;

  function automatic int period(input int sel);
    case (sel)
      0:       return 4;
      1:       return 8;
      2:       return 2;
      default: return 16;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_tick = 0; m_mode = 0; m_col = 1; m_pat = 1;
    m_pos = 0; m_left = 1; m_pbm = 0; m_pbc = 0;
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    e.r    = (m_col & 1) != 0 ? N'(m_pat) : '0;
    e.g    = (m_col & 2) != 0 ? N'(m_pat) : '0;
    e.b    = (m_col & 4) != 0 ? N'(m_pat) : '0;
    e.mode = 2'(m_mode);
    e.tick = m_tick[0];
    return e;
  endfunction

  task automatic model_step(input int en, input int sel, input int dir, input int bm, input int bc);
    int mode_e, col_e, ntick;
    mode_e = (bm != 0) && (m_pbm == 0);
    col_e  = bc & ~m_pbc & 7;
    ntick  = 0;
    if (en == 0 || mode_e != 0) m_cnt = 0;
    else if (m_cnt >= period(sel) - 1) begin m_cnt = 0; ntick = 1; end
    else m_cnt = m_cnt + 1;
    if (col_e != 0) m_col = bc;
    if (mode_e != 0) begin
      m_mode = (m_mode + 1) % 4;
      m_pos  = 0;
      m_left = 1;
      m_pat  = (m_mode == 0 || m_mode == 2) ? 1 : 0;
    end else if (m_tick != 0) begin
      case (m_mode)
        0: m_pat = (dir == 0) ? (((m_pat << 1) | (m_pat >> (N - 1))) & MASK)
                              : ((m_pat >> 1) | ((m_pat & 1) << (N - 1)));
        1: m_pat = ~m_pat & MASK;
        2: begin
          if (m_left != 0) begin
            if (m_pos == N - 1) begin m_left = 0; m_pos = m_pos - 1; end
            else m_pos = m_pos + 1;
          end else begin
            if (m_pos == 0) begin m_left = 1; m_pos = m_pos + 1; end
            else m_pos = m_pos - 1;
          end
          m_pat = 1 << m_pos;
        end
        default: begin
          if (m_pat == MASK) m_pat = 0;
          else if (dir == 0) m_pat = ((m_pat << 1) | 1) & MASK;
          else m_pat = (m_pat >> 1) | (1 << (N - 1));
        end
      endcase
    end
    m_tick = ntick;
    m_pbm  = bm;
    m_pbc  = bc;
  endtask

  task automatic check(input exp_t e, input string name);
    exp_t got;
    got = {bus.o_led_r, bus.o_led_g, bus.o_led_b, bus.o_mode, bus.o_tick};
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got r=%b g=%b b=%b mode=%0d tick=%b, expected r=%b g=%b b=%b mode=%0d tick=%b",
               name, $time, got.r, got.g, got.b, got.mode, got.tick, e.r, e.g, e.b, e.mode, e.tick);
    end
  endtask

  // One clock of stimulus; the expected post-edge response goes to the scoreboard.
  task automatic cycle(input int en, input int sel, input int dir, input int bm, input int bc);
    #1;
    bus.i_enable     = en[0];
    bus.i_period_sel = 2'(sel);
    bus.i_dir        = dir[0];
    bus.i_btn_mode   = bm[0];
    bus.i_btn_color  = 3'(bc);
    model_step(en, sel, dir, bm, bc);
    @(posedge clk);
    q.push_back(expect_now());
  endtask

  // Monitor: compare every presented output cycle against the queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) check(q.pop_front(), "seq");
  end

  initial begin
    int k;
    int sel;
    bus.i_enable = 1'b0; bus.i_period_sel = 2'd0; bus.i_dir = 1'b0;
    bus.i_btn_mode = 1'b0; bus.i_btn_color = 3'b000;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check(expect_now(), "reset_state");
    @(negedge clk) rst_n = 1'b1;

    // Shift left at period 4
    repeat (20) cycle(1, 0, 0, 0, 0);
    // Two mode presses -> bounce
    cycle(1, 0, 0, 1, 0); cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    repeat (30) cycle(1, 0, 0, 0, 0);
    // Fill from MSB side, then switch to filling from LSB
    cycle(1, 0, 1, 1, 0);
    repeat (22) cycle(1, 0, 1, 0, 0);
    repeat (10) cycle(1, 0, 0, 0, 0);
    // Colour: held press, release, red-only press
    repeat (5) cycle(1, 0, 0, 0, 3'b110);
    repeat (10) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 3'b001);
    repeat (6) cycle(1, 0, 0, 0, 0);
    // Mode press on a tick cycle, then complete four presses
    k = 0;
    while (m_tick == 0 && k < 50) begin cycle(1, 0, 0, 0, 0); k++; end
    n_vec++;
    if (k >= 50) begin
      n_bad++;
      $display("FAIL tick_wait: got no tick within %0d cycles, expected one", k);
    end
    cycle(1, 0, 0, 1, 0);
    repeat (3) begin cycle(1, 0, 0, 0, 0); cycle(1, 0, 0, 1, 0); end
    repeat (6) cycle(1, 0, 0, 0, 0);
    // Frozen while disabled
    repeat (20) cycle(0, 0, 0, 0, 0);
    repeat (6) cycle(1, 0, 0, 0, 0);

    // Randomised traffic
    sel = 0;
    repeat (400) begin
      if ($urandom_range(19) == 0) sel = int'($urandom_range(3));
      cycle(($urandom_range(7) != 0) ? 1 : 0, sel, int'($urandom_range(1)),
            ($urandom_range(15) == 0) ? 1 : 0,
            ($urandom_range(9) == 0) ? int'($urandom_range(7)) : 0);
    end

    // Get into FILL, run, then pull reset between clock edges
    k = 0;
    while (m_mode != 3 && k < 8) begin cycle(1, 0, 0, 1, 0); cycle(1, 0, 0, 0, 0); k++; end
    repeat (10) cycle(1, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.i_btn_mode = 1'b0; bus.i_btn_color = 3'b000;
    model_reset();
    #1 check(expect_now(), "async_reset");
    repeat (2) @(posedge clk);
    #1 check(expect_now(), "reset_hold");
    @(negedge clk) rst_n = 1'b1;
    repeat (12) cycle(1, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
